// File: rtl/xor_stream_pkg.sv
// Shared definitions for the xor_stream_unit: beat mode encodings and lane slicing.
package xor_stream_pkg;

  localparam logic [1:0] MODE_XOR  = 2'd0;
  localparam logic [1:0] MODE_ACC  = 2'd1;
  localparam logic [1:0] MODE_CLR  = 2'd2;
  localparam logic [1:0] MODE_HOLD = 2'd3;

  // LSB position of lane 'lane' inside a packed LANES*WIDTH vector.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/xor_lane.sv
// One independent lane: computes a^b, optionally folded into its own running
// XOR accumulator. The result is combinational; the top registers it.
module xor_lane
  import xor_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  input  logic             accept,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] x;

  assign x = a ^ b;

  // Per-mode result; HOLD ignores the operands and exposes the accumulator.
  always_comb begin
    result = x;
    case (mode)
      MODE_XOR:  result = x;
      MODE_ACC:  result = acc ^ x;
      MODE_CLR:  result = x;
      MODE_HOLD: result = acc;
      default:   result = x;
    endcase
  end

  // Accumulator only moves on an accepted ACC or CLR beat; both store the new result.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (accept && (mode == MODE_ACC || mode == MODE_CLR)) begin
      acc <= result;
    end
  end

endmodule

// File: rtl/xor_stream_unit.sv
// Multi-lane XOR / running-checksum unit with valid/ready on both sides and a
// single registered output stage (1-cycle latency, full throughput).
module xor_stream_unit
  import xor_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 2,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  input  logic [1:0]             in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_f,
  output logic [LANES-1:0]       out_par,
  output logic [CNT_W-1:0]       out_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic                   accept;
  logic [LANES*WIDTH-1:0] next_f;
  logic [CNT_W-1:0]       next_cnt;

  // Blocked during reset so nothing is accepted while state is being cleared.
  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    xor_lane #(
      .WIDTH (WIDTH)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .a      (in_a[lane_lsb(i, WIDTH) +: WIDTH]),
      .b      (in_b[lane_lsb(i, WIDTH) +: WIDTH]),
      .mode   (in_mode),
      .accept (accept),
      .result (next_f[lane_lsb(i, WIDTH) +: WIDTH])
    );

    assign out_par[i] = ^out_f[lane_lsb(i, WIDTH) +: WIDTH];
  end

  // Beat counter value for the incoming beat: CLR restarts at 1, others saturate upward.
  always_comb begin
    next_cnt = out_cnt;
    if (in_mode == MODE_CLR) begin
      next_cnt = CNT_W'(1);
    end else if (out_cnt != CNT_MAX) begin
      next_cnt = out_cnt + CNT_W'(1);
    end
  end

  // Output stage: load on accept, drop valid on a fire without a new beat.
  // out_f deliberately keeps its last value when valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_f     <= '0;
      out_cnt   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_f     <= next_f;
      out_cnt   <= next_cnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xor_stream_unit.sv
// Directed bench for xor_stream_unit: a vector table for the per-beat function
// plus hand-written sequences for stalls, throughput, saturation and reset.
module tb_xor_stream_unit;
  import xor_stream_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_f;
  logic [1:0]  out_par;
  logic [7:0]  out_cnt;

  logic        in_ready2;
  logic        out_valid2;
  logic [15:0] out_f2;
  logic [1:0]  out_par2;
  logic [1:0]  out_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xor_stream_unit #(.WIDTH(8), .LANES(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_f(out_f), .out_par(out_par), .out_cnt(out_cnt)
  );

  // Narrow-counter copy sharing the same stimulus, used for saturation.
  xor_stream_unit #(.WIDTH(8), .LANES(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid2),
    .out_ready(out_ready), .out_f(out_f2), .out_par(out_par2), .out_cnt(out_cnt2)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_f;
    logic [1:0]  exp_par;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] mode, input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1;
    in_mode  = mode;
    in_a     = a;
    in_b     = b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{MODE_XOR,  16'h0FA5, 16'hFF5A, 16'hF0FF, 2'b00, 8'd1};
    vecs[1] = '{MODE_CLR,  16'h0101, 16'h0000, 16'h0101, 2'b11, 8'd1};
    vecs[2] = '{MODE_ACC,  16'h0202, 16'h0000, 16'h0303, 2'b00, 8'd2};
    vecs[3] = '{MODE_ACC,  16'h0303, 16'h0202, 16'h0202, 2'b11, 8'd3};
    vecs[4] = '{MODE_HOLD, 16'hFFFF, 16'h1234, 16'h0202, 2'b11, 8'd4};
    vecs[5] = '{MODE_XOR,  16'h1234, 16'h00FF, 16'h12CB, 2'b01, 8'd5};
    vecs[6] = '{MODE_HOLD, 16'h0000, 16'h0000, 16'h0202, 2'b11, 8'd6};
    vecs[7] = '{MODE_CLR,  16'hABCD, 16'h0000, 16'hABCD, 2'b11, 8'd1};
    vecs[8] = '{MODE_ACC,  16'hFF00, 16'h0000, 16'h54CD, 2'b11, 8'd2};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = MODE_XOR; out_ready = 1'b1;
    step();
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_f",     32'(out_f),     32'd0);
    check("rst_out_par",   32'(out_par),   32'd0);
    check("rst_out_cnt",   32'(out_cnt),   32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back beats from the table; each result is visible right after the edge.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].mode, vecs[i].a, vecs[i].b);
      step();
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_f", i),     32'(out_f),     32'(vecs[i].exp_f));
      check($sformatf("vec%0d_par", i),   32'(out_par),   32'(vecs[i].exp_par));
      check($sformatf("vec%0d_cnt", i),   32'(out_cnt),   32'(vecs[i].exp_cnt));
      check($sformatf("vec%0d_cnt2", i),  32'(out_cnt2),
            32'((vecs[i].exp_cnt > 8'd3) ? 8'd3 : vecs[i].exp_cnt));
    end

    // Backpressure: acc is 54CD here.
    drive(MODE_ACC, 16'h0101, 16'h0000);
    step();
    check("bp_first_f",   32'(out_f),   32'h55CC);
    check("bp_first_cnt", 32'(out_cnt), 32'd3);
    out_ready = 1'b0;
    drive(MODE_ACC, 16'h0202, 16'h0000);
    #1;
    check("bp_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("bp_stall%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("bp_stall%0d_f", i),     32'(out_f),     32'h55CC);
      check($sformatf("bp_stall%0d_cnt", i),   32'(out_cnt),   32'd3);
      check($sformatf("bp_stall%0d_ready", i), 32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    step();
    check("bp_pending_f",   32'(out_f),     32'h57CE);
    check("bp_pending_cnt", 32'(out_cnt),   32'd4);
    check("bp_pending_vld", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    step();
    check("bp_drain_valid", 32'(out_valid), 32'd0);
    check("bp_drain_f",     32'(out_f),     32'h57CE);
    step();
    check("bp_nodup_valid", 32'(out_valid), 32'd0);

    // Full throughput after CLR; the narrow copy must saturate at 3.
    drive(MODE_CLR, 16'h0001, 16'h0000);
    step();
    check("tp_clr_f",    32'(out_f),    32'h0001);
    check("tp_clr_cnt",  32'(out_cnt),  32'd1);
    check("tp_clr_cnt2", 32'(out_cnt2), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      drive(MODE_ACC, 16'h0001, 16'h0000);
      step();
      check($sformatf("tp%0d_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("tp%0d_f", k),     32'(out_f),     (k % 2 == 1) ? 32'h0000 : 32'h0001);
      check($sformatf("tp%0d_cnt", k),   32'(out_cnt),   32'(k + 1));
      check($sformatf("tp%0d_cnt2", k),  32'(out_cnt2),  (k + 1 > 3) ? 32'd3 : 32'(k + 1));
    end
    check("tp_final_cnt", 32'(out_cnt), 32'd11);

    // Reset while a result is pending and acc = ABCD.
    drive(MODE_CLR, 16'hABCD, 16'h0000);
    step();
    check("mr_pre_f", 32'(out_f), 32'hABCD);
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    check("mr_valid", 32'(out_valid), 32'd0);
    check("mr_cnt",   32'(out_cnt),   32'd0);
    check("mr_f",     32'(out_f),     32'd0);
    rst = 1'b0;
    drive(MODE_HOLD, 16'h5555, 16'h3333);
    step();
    check("mr_hold_valid", 32'(out_valid), 32'd1);
    check("mr_hold_f",     32'(out_f),     32'd0);
    check("mr_hold_par",   32'(out_par),   32'd0);
    check("mr_hold_cnt",   32'(out_cnt),   32'd1);
    in_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xor_stream_unit.md
Name: xor_stream_unit

Overview:
- Parametrised, pipelined successor to the single-bit XOR gate at the top of the npc design.
- Processes LANES independent WIDTH-bit lanes per beat. Each lane computes a^b, either directly or folded into a per-lane running XOR accumulator (checksum).
- Input and output use valid/ready handshakes; output is registered with 1-cycle latency.
- Sits between a stimulus source (testbench or bus adapter) and a checker or result sink in the npc simulation top.

Parameters:
- WIDTH, 8, bits per lane operand.
- LANES, 2, number of independent lanes.
- CNT_W, 8, width of the saturating beat counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  input beat valid.
- in_ready  output  1  unit can accept a beat this cycle.
- in_a  input  LANES*WIDTH  operand A; lane i occupies bits [i*WIDTH +: WIDTH].
- in_b  input  LANES*WIDTH  operand B, same packing as in_a.
- in_mode  input  2  operation for this beat: 0 XOR, 1 ACC, 2 CLR, 3 HOLD.
- out_valid  output  1  result beat valid.
- out_ready  input  1  sink accepts the result.
- out_f  output  LANES*WIDTH  per-lane result.
- out_par  output  LANES  out_par[i] = reduction XOR of lane i of out_f.
- out_cnt  output  CNT_W  beats accepted since the last CLR or reset, including the current beat.

Behaviour:
- Reset (rst=1 at clock edge):
  - out_valid=0, out_f=0, out_par=0, out_cnt=0.
  - All accumulators = 0.
  - Any pending output is discarded.
  - in_ready reads 0 during the reset cycle.
- Handshakes:
  - Accept when in_valid && in_ready.
  - Output fire when out_valid && out_ready.
  - in_ready = !out_valid || out_ready, so back-to-back beats run at full throughput.
- Latency: an accepted beat's result appears on out_f / out_valid in the next cycle.
- Backpressure: while out_valid && !out_ready, out_f, out_par, out_cnt and out_valid hold stable, and no accumulator changes.
- Per-lane function on accept, with x = a_i ^ b_i:
  - XOR (0): out = x; accumulator unchanged.
  - ACC (1): acc_i <= acc_i ^ x; out = acc_i ^ x (the new value).
  - CLR (2): acc_i <= x; out = x.
  - HOLD (3): out = acc_i; accumulator unchanged; operands are ignored.
- Counter:
  - On accept: CLR loads 1; every other mode increments the counter.
  - Saturates at 2^CNT_W-1, with no wrap.
  - out_cnt is registered alongside out_f.
- Simultaneous accept and output fire in the same cycle: the new result replaces the old one; out_valid stays 1.
- Output fire with no accept: out_valid <= 0. out_f retains its last value (not cleared).
- No accept: accumulators and counter are unchanged.
- All arithmetic is bitwise, with no carries. Lanes are fully independent.
- out_par is derived combinationally from the registered out_f.

Decomposition:
- Package xor_stream_pkg holds:
  - mode encoding constants MODE_XOR=2'd0, MODE_ACC=2'd1, MODE_CLR=2'd2, MODE_HOLD=2'd3;
  - a helper function for lane slicing.
- Sub-module xor_lane (instantiated LANES times via generate):
  - inputs: WIDTH-bit a, b, mode, accept;
  - owns its accumulator register;
  - outputs next result.
- The top level owns the handshake, the output register, the counter and parity.

Test Plan:
- Reset then single XOR (LANES=2, WIDTH=8):
  - Stimulus: a=16'h0F_A5, b=16'hFF_5A, mode 0, out_ready=1.
  - Response: next cycle out_f=16'hF0_FF, out_par=2'b00, out_cnt=1.
- ACC chain:
  - Stimulus: CLR with a^b=16'h0101, then ACC 16'h0202, then ACC 16'h0101.
  - Response: out_f sequence 0101, 0303, 0202; out_cnt sequence 1, 2, 3.
- Backpressure:
  - Stimulus: hold out_ready=0 for 3 cycles with in_valid=1.
  - Response: in_ready=0, out_f held stable, accumulator unchanged.
  - On release: the pending beat completes one cycle later, with no loss or duplication.
- Full throughput:
  - Stimulus: 10 consecutive ACC beats, out_ready=1.
  - Response: 10 consecutive out_valid cycles; final out_cnt=11 after an initial CLR.
- Counter saturation:
  - Stimulus: CNT_W=2, 6 accepted beats after CLR.
  - Response: out_cnt=1,2,3,3,3,3.
- Reset mid-operation:
  - Stimulus: assert rst while out_valid=1 and acc=16'hABCD.
  - Response: next cycle out_valid=0, out_cnt=0; a following HOLD beat yields out_f=0.
